instruction_fetch_unit: RTL and testbench

- Fetches 16-bit AVR opcodes from program memory and feeds the instruction decoder.
- Drives the decoder's `instruction` bus and `part2` flag. `part2` marks the second word of a 32-bit opcode: CALL, JMP, LDS or STS.
- Owns the program counter and honours redirects from the control path (jumps, branches, calls, returns, interrupts).
- Single outstanding memory request; one-entry registered output buffer with a valid/ready handshake.

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 70 +++++++
 tb/tb_instruction_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: program-memory, redirect and decoder-side signals of the fetch unit
// master: fetch unit (drives pm_rd_en/pm_addr and the decoder outputs)
// slave:  environment (memory, control path redirect, decoder)
interface instruction_fetch_unit_if #(parameter int ADDR_WIDTH = 14);
  logic                  pm_rd_en;
  logic [ADDR_WIDTH-1:0] pm_addr;
  logic [15:0]           pm_rdata;
  logic                  pm_valid;
  logic                  pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_value;
  logic [15:0]           instruction;
  logic                  part2;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  modport master (
    output pm_rd_en, pm_addr, instruction, part2, instr_pc, instr_valid,
    input  pm_rdata, pm_valid, pc_load, pc_load_value, instr_ready
  );
  modport slave (
    input  pm_rd_en, pm_addr, instruction, part2, instr_pc, instr_valid,
    output pm_rdata, pm_valid, pc_load, pc_load_value, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches 16-bit AVR opcodes, tags second words of 32-bit opcodes, owns the PC
// clk, rst_n (async, active-low)
// fetch_if.master: pm_rd_en/pm_addr/pm_rdata/pm_valid memory port, pc_load/pc_load_value redirect,
//                  instruction/part2/instr_pc/instr_valid/instr_ready decoder handshake
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic                       clk,
  input logic                       rst_n,
  instruction_fetch_unit_if.master  fetch_if
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic [15:0]           instr_q;
  logic                  part2_q;
  logic                  valid_q;
  logic                  expect_q;
  logic                  is32_d;
  logic [15:0]           w;
  assign w = fetch_if.pm_rdata;
  assign is32_d = ((w & 16'hFE0E) == 16'h940E) | ((w & 16'hFE0E) == 16'h940C) |
                  ((w & 16'hFE0F) == 16'h9000) | ((w & 16'hFE0F) == 16'h9200);
  assign fetch_if.pm_rd_en    = (state_q == FETCH) & ~fetch_if.pc_load;
  assign fetch_if.pm_addr     = pc_q;
  assign fetch_if.instruction = instr_q;
  assign fetch_if.part2       = part2_q;
  assign fetch_if.instr_pc    = instr_pc_q;
  assign fetch_if.instr_valid = valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      expect_q   <= 1'b0;
      instr_q    <= '0;
      part2_q    <= 1'b0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (fetch_if.pc_load) begin
      pc_q     <= fetch_if.pc_load_value;
      expect_q <= 1'b0;
      valid_q  <= 1'b0;
      // a request still in flight must be drained before the redirected fetch can issue
      state_q  <= ((state_q == WAIT || state_q == DRAIN) && !fetch_if.pm_valid) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        IDLE:  state_q <= FETCH;
        FETCH: state_q <= WAIT;
        WAIT: if (fetch_if.pm_valid) begin
          instr_q    <= w;
          instr_pc_q <= pc_q;
          part2_q    <= expect_q;
          valid_q    <= 1'b1;
          // a second word is never classified, so part2 never chains
          expect_q   <= is32_d & ~expect_q;
          pc_q       <= pc_q + ADDR_WIDTH'(1);
          state_q    <= HOLD;
        end
        HOLD: if (valid_q && fetch_if.instr_ready) begin
          valid_q <= 1'b0;
          state_q <= FETCH;
        end
        DRAIN: if (fetch_if.pm_valid) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized and directed checks of the fetch unit against a transaction-level model
module tb_instruction_fetch_unit;
  localparam int             AW = 14;
  localparam logic [AW-1:0]  RV = 14'h3FFF;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  instruction_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();
  instruction_fetch_unit #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_if(bus)
  );
  int total = 0;
  int bad = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask
  function automatic logic is32(input logic [15:0] x);
    return (x[15:9] == 7'b1001010 && x[3:2] == 2'b11) ||
           (x[15:9] == 7'b1001000 && x[3:0] == 4'h0) ||
           (x[15:9] == 7'b1001001 && x[3:0] == 4'h0);
  endfunction
  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(5))
      0: r = {7'b1001010, r[8:4], 3'b111, r[0]};
      1: r = {7'b1001010, r[8:4], 3'b110, r[0]};
      2: r = {7'b1001000, r[8:4], 4'h0};
      3: r = {7'b1001001, r[8:4], 4'h0};
      default: ;
    endcase
    return r;
  endfunction
  logic [15:0] mem [0:(1<<AW)-1];
  int lat = 1;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    int cnt;
    logic [AW-1:0] raddr;
    cnt = 0;
    raddr = '0;
    bus.pm_valid = 1'b0;
    bus.pm_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pm_rd_en) begin
        raddr = bus.pm_addr;
        cnt = lat;
      end
      @(posedge clk);
      #1;
      bus.pm_valid = 1'b0;
      bus.pm_rdata = 16'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.pm_valid = 1'b1;
          bus.pm_rdata = mem[raddr];
        end
      end
    end
  end
  logic [AW-1:0] mpc = RV;
  logic          mexp = 1'b0;
  logic          hold = 1'b0;
  logic [15:0]   hw;
  logic [AW-1:0] hpc;
  logic          hp2;
  int            txn = 0;
  logic [AW-1:0] tx_pc [$];
  logic          tx_p2 [$];
  logic [15:0]   tx_w [$];
  int            tx_cyc [$];
  logic [AW-1:0] req_q [$];
  task automatic clear_logs();
    tx_pc.delete();
    tx_p2.delete();
    tx_w.delete();
    tx_cyc.delete();
    req_q.delete();
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      mpc = RV;
      mexp = 1'b0;
      hold = 1'b0;
    end else begin
      if (bus.pm_rd_en) begin
        check("pm_addr", 32'(bus.pm_addr), 32'(mpc));
        req_q.push_back(bus.pm_addr);
      end
      if (hold) begin
        check("hold_valid", 32'(bus.instr_valid), 32'd1);
        check("hold_word", 32'(bus.instruction), 32'(hw));
        check("hold_pc", 32'(bus.instr_pc), 32'(hpc));
        check("hold_part2", 32'(bus.part2), 32'(hp2));
      end
      if (bus.instr_valid && bus.instr_ready) begin
        check("tx_pc", 32'(bus.instr_pc), 32'(mpc));
        check("tx_word", 32'(bus.instruction), 32'(mem[mpc]));
        check("tx_part2", 32'(bus.part2), 32'(mexp));
        tx_pc.push_back(bus.instr_pc);
        tx_p2.push_back(bus.part2);
        tx_w.push_back(bus.instruction);
        tx_cyc.push_back(cyc);
        txn++;
        mexp = is32(mem[mpc]) && !mexp;
        mpc = mpc + 1'b1;
      end
      hold = bus.instr_valid && !bus.instr_ready && !bus.pc_load;
      hw = bus.instruction;
      hpc = bus.instr_pc;
      hp2 = bus.part2;
      if (bus.pc_load) begin
        mpc = bus.pc_load_value;
        mexp = 1'b0;
      end
    end
  end
  task automatic wait_tx(input int n);
    for (int k = 0; k < 100 && tx_pc.size() < n; k++) @(posedge clk);
    #1;
    check("tx_count", 32'(tx_pc.size() >= n), 32'd1);
  endtask
  task automatic redirect(input logic [AW-1:0] a);
    @(posedge clk);
    #1;
    bus.pc_load = 1'b1;
    bus.pc_load_value = a;
    @(posedge clk);
    #1;
    bus.pc_load = 1'b0;
    clear_logs();
  endtask
  task automatic wait_req();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.pm_rd_en) break;
    end
    check("req_seen", 32'(bus.pm_rd_en), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] p32 [5];
    logic        e32 [5];
    for (int i = 0; i < (1 << AW); i++) mem[i] = rand_word();
    mem[14'h3FFF] = 16'hE0FF;
    mem[0] = 16'h0C01; mem[1] = 16'h2C23; mem[2] = 16'hE0FF;
    p32 = '{16'h940E, 16'h0123, 16'h9100, 16'h0060, 16'h0000};
    e32 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) mem[14'h10 + i] = p32[i];
    mem[14'h20] = 16'h940C; mem[14'h21] = 16'h940E; mem[14'h22] = 16'h0000;
    mem[14'h30] = 16'hE0FF;
    mem[14'h40] = 16'h940E;
    mem[14'h100] = 16'h1234;
    bus.pc_load = 1'b0;
    bus.pc_load_value = '0;
    bus.instr_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instruction), 32'd0);
    check("rst_part2", 32'(bus.part2), 32'd0);
    check("rst_ipc", 32'(bus.instr_pc), 32'd0);
    check("rst_rd_en", 32'(bus.pm_rd_en), 32'd0);
    check("rst_addr", 32'(bus.pm_addr), 32'(RV));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    lat = 1;
    clear_logs();
    wait_tx(4);
    check("wrap_pc0", 32'(tx_pc[0]), 32'h3FFF);
    check("wrap_pc1", 32'(tx_pc[1]), 32'h0000);
    check("line_pc2", 32'(tx_pc[3]), 32'h0002);
    check("line_w1", 32'(tx_w[2]), 32'h2C23);
    check("line_p2", 32'({tx_p2[0], tx_p2[1], tx_p2[2], tx_p2[3]}), 32'd0);
    check("period_a", 32'(tx_cyc[2] - tx_cyc[1]), 32'd3);
    check("period_b", 32'(tx_cyc[3] - tx_cyc[2]), 32'd3);
    check("first_req", 32'(req_q[0]), 32'h3FFF);
    redirect(14'h10);
    wait_tx(5);
    for (int i = 0; i < 5; i++) begin
      check("op32_pc", 32'(tx_pc[i]), 32'(14'h10 + i));
      check("op32_part2", 32'(tx_p2[i]), 32'(e32[i]));
    end
    redirect(14'h20);
    wait_tx(3);
    check("lookalike_p0", 32'(tx_p2[0]), 32'd0);
    check("lookalike_p1", 32'(tx_p2[1]), 32'd1);
    check("lookalike_p2", 32'(tx_p2[2]), 32'd0);
    bus.instr_ready = 1'b0;
    redirect(14'h30);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.instr_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_word", 32'(bus.instruction), 32'hE0FF);
      check("bp_pc", 32'(bus.instr_pc), 32'h30);
      check("bp_no_req", 32'(bus.pm_rd_en), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("bp_tx_no_req", 32'(bus.pm_rd_en), 32'd0);
    @(posedge clk);
    #1;
    check("bp_tx_count", 32'(tx_pc.size()), 32'd1);
    @(negedge clk);
    check("bp_next_req", 32'(bus.pm_rd_en), 32'd1);
    check("bp_next_addr", 32'(bus.pm_addr), 32'h31);
    lat = 3;
    redirect(14'h40);
    wait_req();
    @(posedge clk);
    #1;
    bus.pc_load = 1'b1;
    bus.pc_load_value = 14'h100;
    @(posedge clk);
    #1;
    bus.pc_load = 1'b0;
    clear_logs();
    wait_tx(1);
    check("drain_pc", 32'(tx_pc[0]), 32'h100);
    check("drain_part2", 32'(tx_p2[0]), 32'd0);
    check("drain_word", 32'(tx_w[0]), 32'h1234);
    check("drain_req", 32'(req_q[0]), 32'h100);
    wait_req();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("mid_rst_instr", 32'(bus.instruction), 32'd0);
    check("mid_rst_part2", 32'(bus.part2), 32'd0);
    check("mid_rst_ipc", 32'(bus.instr_pc), 32'd0);
    check("mid_rst_rd_en", 32'(bus.pm_rd_en), 32'd0);
    check("mid_rst_addr", 32'(bus.pm_addr), 32'(RV));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat = 1;
    clear_logs();
    wait_tx(2);
    check("post_rst_req", 32'(req_q[0]), 32'h3FFF);
    check("post_rst_pc0", 32'(tx_pc[0]), 32'h3FFF);
    check("post_rst_pc1", 32'(tx_pc[1]), 32'h0000);
    txn = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      bus.instr_ready = ($urandom_range(3) != 0);
      bus.pc_load = ($urandom_range(24) == 0);
      bus.pc_load_value = AW'($urandom);
      lat = $urandom_range(3, 1);
    end
    @(posedge clk);
    #1;
    bus.pc_load = 1'b0;
    check("random_progress", 32'(txn >= 100), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
